// File: rtl/regfile_pkg.sv
// Shared sizes and index type for the register-file operand fetch stage.
package regfile_pkg;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;

   typedef logic [ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-destination scoreboard: one bit per register, with lookups that
// see a same-cycle write-back clear so the issue stage need not wait a cycle.
module reg_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W      = regfile_pkg::ADDR_W,
   parameter bit HARDWIRE_R0 = 1'b0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                set_en,
   input  logic [ADDR_W-1:0]   set_idx,
   input  logic                clr_en,
   input  logic [ADDR_W-1:0]   clr_idx,
   input  logic [ADDR_W-1:0]   look_rs1,
   input  logic [ADDR_W-1:0]   look_rs2,
   input  logic [ADDR_W-1:0]   look_rd,
   output logic                hit_rs1,
   output logic                hit_rs2,
   output logic                hit_rd,
   output logic                clr_miss,
   output logic [NUM_REGS-1:0] pending
);

   logic [NUM_REGS-1:0] pending_nxt;

   always_comb begin
      hit_rs1  = pending[look_rs1] && !(clr_en && clr_idx == look_rs1);
      hit_rs2  = pending[look_rs2] && !(clr_en && clr_idx == look_rs2);
      hit_rd   = pending[look_rd]  && !(clr_en && clr_idx == look_rd);
      clr_miss = clr_en && !pending[clr_idx];
   end

   // Clear first, then set, so a new owner of the same index stays pending.
   always_comb begin
      pending_nxt = pending;
      if (clr_en)
         pending_nxt[clr_idx] = 1'b0;
      if (set_en && !(HARDWIRE_R0 && set_idx == '0))
         pending_nxt[set_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         pending <= '0;
      else
         pending <= pending_nxt;
   end

endmodule

// File: rtl/regfile_operand_fetch.sv
// Operand fetch between decode and execute: drives the register-file ports,
// stalls on RAW/WAW hazards and registers the bypassed operand pair.
module regfile_operand_fetch
   import regfile_pkg::*;
#(
   parameter int DATA_W      = regfile_pkg::DATA_W,
   parameter int ADDR_W      = regfile_pkg::ADDR_W,
   parameter bit HARDWIRE_R0 = 1'b0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                issue_valid,
   output logic                issue_ready,
   input  logic [ADDR_W-1:0]   issue_rs1,
   input  logic [ADDR_W-1:0]   issue_rs2,
   input  logic                issue_use_rs1,
   input  logic                issue_use_rs2,
   input  logic                issue_wr_en,
   input  logic [ADDR_W-1:0]   issue_rd,
   input  logic                wb_valid,
   input  logic [ADDR_W-1:0]   wb_rd,
   input  logic [DATA_W-1:0]   wb_data,
   output logic [ADDR_W-1:0]   rf_rs1,
   output logic [ADDR_W-1:0]   rf_rs2,
   output logic                rf_rf,
   input  logic [DATA_W-1:0]   rf_rd1,
   input  logic [DATA_W-1:0]   rf_rd2,
   output logic [ADDR_W-1:0]   rf_ws,
   output logic [DATA_W-1:0]   rf_wd,
   output logic                rf_wf,
   output logic                op_valid,
   input  logic                op_ready,
   output logic [DATA_W-1:0]   op_a,
   output logic [DATA_W-1:0]   op_b,
   output logic [ADDR_W-1:0]   op_rd,
   output logic                op_wr_en,
   output logic [NUM_REGS-1:0] pending,
   output logic                sb_err
);

   logic              hit_rs1;
   logic              hit_rs2;
   logic              hit_rd;
   logic              clr_miss;
   logic              raw1;
   logic              raw2;
   logic              waw;
   logic              accept;
   logic [DATA_W-1:0] src_a;
   logic [DATA_W-1:0] src_b;

   reg_scoreboard #(
      .ADDR_W      (ADDR_W),
      .HARDWIRE_R0 (HARDWIRE_R0)
   ) u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (accept && issue_wr_en),
      .set_idx  (issue_rd),
      .clr_en   (wb_valid),
      .clr_idx  (wb_rd),
      .look_rs1 (issue_rs1),
      .look_rs2 (issue_rs2),
      .look_rd  (issue_rd),
      .hit_rs1  (hit_rs1),
      .hit_rs2  (hit_rs2),
      .hit_rd   (hit_rd),
      .clr_miss (clr_miss),
      .pending  (pending)
   );

   always_comb begin
      rf_rs1 = issue_rs1;
      rf_rs2 = issue_rs2;
      rf_rf  = rst_n && issue_valid;
      rf_ws  = wb_rd;
      rf_wd  = wb_data;
      rf_wf  = rst_n && wb_valid && !(HARDWIRE_R0 && wb_rd == '0);
   end

   always_comb begin
      raw1        = issue_use_rs1 && hit_rs1;
      raw2        = issue_use_rs2 && hit_rs2;
      waw         = issue_wr_en && hit_rd;
      issue_ready = rst_n && !raw1 && !raw2 && !waw && (!op_valid || op_ready);
      accept      = issue_valid && issue_ready;
   end

   // Bypass unconditionally on a matching write-back: the register file may
   // or may not already show the new value depending on its write timing.
   always_comb begin
      if (HARDWIRE_R0 && issue_rs1 == '0)
         src_a = '0;
      else if (wb_valid && wb_rd == issue_rs1)
         src_a = wb_data;
      else
         src_a = rf_rd1;

      if (HARDWIRE_R0 && issue_rs2 == '0)
         src_b = '0;
      else if (wb_valid && wb_rd == issue_rs2)
         src_b = wb_data;
      else
         src_b = rf_rd2;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_valid <= 1'b0;
         op_a     <= '0;
         op_b     <= '0;
         op_rd    <= '0;
         op_wr_en <= 1'b0;
      end else if (accept) begin
         op_valid <= 1'b1;
         op_a     <= src_a;
         op_b     <= src_b;
         op_rd    <= issue_rd;
         op_wr_en <= issue_wr_en;
      end else if (op_ready) begin
         op_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         sb_err <= 1'b0;
      else if (clr_miss)
         sb_err <= 1'b1;
   end

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Directed bench for regfile_operand_fetch: expected operand pairs queued at
// issue time and compared after the capturing edge; pending/sb_err modelled.
module tb_regfile_operand_fetch;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        we;
   } op_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue_valid, issue_ready;
   logic [4:0]  issue_rs1, issue_rs2, issue_rd;
   logic        issue_use_rs1, issue_use_rs2, issue_wr_en;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [4:0]  rf_rs1, rf_rs2, rf_ws;
   logic        rf_rf, rf_wf;
   logic [31:0] rf_rd1, rf_rd2, rf_wd;
   logic        op_valid, op_ready, op_wr_en;
   logic [31:0] op_a, op_b;
   logic [4:0]  op_rd;
   logic [31:0] pending;
   logic        sb_err;

   int checks = 0;
   int errors = 0;

   op_t         exp_q[$];
   op_t         cur;
   logic [31:0] exp_pending = '0;
   logic        exp_valid   = 1'b0;
   logic        exp_sberr   = 1'b0;

   always #5 clk = ~clk;

   regfile_operand_fetch dut (
      .clk(clk), .rst_n(rst_n),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
      .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
      .issue_wr_en(issue_wr_en), .issue_rd(issue_rd),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rf(rf_rf),
      .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
      .rf_ws(rf_ws), .rf_wd(rf_wd), .rf_wf(rf_wf),
      .op_valid(op_valid), .op_ready(op_ready),
      .op_a(op_a), .op_b(op_b), .op_rd(op_rd), .op_wr_en(op_wr_en),
      .pending(pending), .sb_err(sb_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0;
      issue_use_rs1 = 0; issue_use_rs2 = 0; issue_wr_en = 0; issue_rd = 0;
      wb_valid = 0; wb_rd = 0; wb_data = 0;
   endtask

   task automatic issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                        input logic u2, input logic [4:0] rd, input logic we);
      issue_valid = 1; issue_rs1 = rs1; issue_use_rs1 = u1;
      issue_rs2 = rs2; issue_use_rs2 = u2; issue_rd = rd; issue_wr_en = we;
   endtask

   task automatic wb(input logic [4:0] rd, input logic [31:0] d);
      wb_valid = 1; wb_rd = rd; wb_data = d;
   endtask

   // One clock: check combinational outputs, update the model, then check
   // registered outputs just after the edge.
   task automatic tick(input logic exp_rdy);
      logic        acc;
      logic [31:0] nxt;
      op_t         e;
      #2;
      chk("issue_ready", {31'b0, issue_ready}, {31'b0, exp_rdy});
      chk("rf_rf", {31'b0, rf_rf}, {31'b0, rst_n & issue_valid});
      chk("rf_wf", {31'b0, rf_wf}, {31'b0, rst_n & wb_valid});
      if (wb_valid) begin
         chk("rf_ws", {27'b0, rf_ws}, {27'b0, wb_rd});
         chk("rf_wd", rf_wd, wb_data);
      end
      acc = issue_valid && exp_rdy;
      if (acc) begin
         e.a  = (wb_valid && wb_rd == issue_rs1) ? wb_data : rf_rd1;
         e.b  = (wb_valid && wb_rd == issue_rs2) ? wb_data : rf_rd2;
         e.rd = issue_rd;
         e.we = issue_wr_en;
         exp_q.push_back(e);
      end
      nxt = exp_pending;
      if (wb_valid) nxt[wb_rd] = 1'b0;
      if (acc && issue_wr_en) nxt[issue_rd] = 1'b1;
      if (!rst_n) begin
         exp_pending = '0; exp_valid = 0; exp_sberr = 0; exp_q.delete();
      end else begin
         if (wb_valid && !exp_pending[wb_rd]) exp_sberr = 1'b1;
         exp_pending = nxt;
         if (acc) exp_valid = 1'b1;
         else if (op_ready) exp_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("pending", pending, exp_pending);
      chk("sb_err", {31'b0, sb_err}, {31'b0, exp_sberr});
      chk("op_valid", {31'b0, op_valid}, {31'b0, exp_valid});
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      if (exp_valid) begin
         chk("op_a", op_a, cur.a);
         chk("op_b", op_b, cur.b);
         chk("op_rd", {27'b0, op_rd}, {27'b0, cur.rd});
         chk("op_wr_en", {31'b0, op_wr_en}, {31'b0, cur.we});
      end
   endtask

   initial begin
      cur = '0;
      idle();
      rst_n = 0; op_ready = 1; rf_rd1 = 0; rf_rd2 = 0;
      @(posedge clk); #1;

      // reset with activity on both sides
      issue(1, 1, 2, 1, 3, 1);
      wb(4, 32'h1234);
      tick(0);
      tick(0);
      chk("rst_op_a", op_a, 32'h0);
      chk("rst_op_rd", {27'b0, op_rd}, 32'h0);
      rst_n = 1; idle();
      tick(1);

      // basic read
      issue(2, 1, 3, 1, 4, 0); rf_rd1 = 32'h11; rf_rd2 = 32'h22;
      tick(1);
      idle();
      tick(1);

      // RAW stall then bypass
      issue(0, 0, 0, 0, 5, 1);
      tick(1);
      chk("pend5_set", {31'b0, pending[5]}, 32'h1);
      issue(5, 1, 6, 1, 8, 0); rf_rd1 = 32'h55; rf_rd2 = 32'h66;
      tick(0);
      tick(0);
      wb(5, 32'hDEADBEEF);
      tick(1);
      chk("raw_bypass", op_a, 32'hDEADBEEF);

      // backpressure and same-cycle drain/refill
      idle();
      issue(1, 1, 2, 1, 10, 0); rf_rd1 = 32'hAAAA; rf_rd2 = 32'hBBBB;
      tick(1);
      op_ready = 0;
      issue(11, 1, 12, 1, 13, 0); rf_rd1 = 32'hCCCC; rf_rd2 = 32'hDDDD;
      for (int i = 0; i < 4; i++) tick(0);
      chk("bp_hold_a", op_a, 32'hAAAA);
      op_ready = 1;
      tick(1);
      chk("bp_refill_b", op_b, 32'hDDDD);

      // WAW: stall, then set wins against same-index write-back
      issue(0, 0, 0, 0, 7, 1);
      tick(1);
      tick(0);
      wb(7, 32'h77);
      tick(1);
      chk("waw_pend7", {31'b0, pending[7]}, 32'h1);

      // spurious write-back is sticky
      idle();
      wb(9, 32'h99);
      tick(1);
      idle();
      tick(1);
      wb(7, 32'h70);
      tick(1);
      idle();
      tick(1);
      chk("sberr_sticky", {31'b0, sb_err}, 32'h1);

      // reset clears the sticky error
      rst_n = 0;
      tick(0);
      rst_n = 1;
      tick(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/regfile_operand_fetch.md
Name: regfile_operand_fetch

Overview:
- Initiator side of the 32x32 register-file port interface: rs1/rs2/ws/wd/rf/wf out, rd1/rd2 in.
- Sits between decode and execute in the pipelined processor.
- Accepts issue requests, drives register-file read and write ports, and tracks in-flight destinations in a scoreboard to stall RAW/WAW hazards.
- Bypasses same-cycle write-back data and presents a registered operand pair to execute over a valid/ready handshake.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register index width (32 registers)
- HARDWIRE_R0, 0, when 1: register 0 never goes pending, writes to it are suppressed, and reads of it return 0

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- issue_valid  in  1  decode presents an instruction
- issue_ready  out  1  instruction accepted this cycle when issue_valid is also high
- issue_rs1  in  ADDR_W  source 1 index
- issue_rs2  in  ADDR_W  source 2 index
- issue_use_rs1  in  1  source 1 is read (hazard-checked)
- issue_use_rs2  in  1  source 2 is read (hazard-checked)
- issue_wr_en  in  1  instruction will write a destination
- issue_rd  in  ADDR_W  destination index
- wb_valid  in  1  write-back request
- wb_rd  in  ADDR_W  write-back index
- wb_data  in  DATA_W  write-back data
- rf_rs1  out  ADDR_W  register-file read address 1
- rf_rs2  out  ADDR_W  register-file read address 2
- rf_rf  out  1  register-file read enable
- rf_rd1  in  DATA_W  register-file read data 1
- rf_rd2  in  DATA_W  register-file read data 2
- rf_ws  out  ADDR_W  register-file write address
- rf_wd  out  DATA_W  register-file write data
- rf_wf  out  1  register-file write enable
- op_valid  out  1  operand pair valid to execute
- op_ready  in  1  execute accepts the operand pair
- op_a  out  DATA_W  operand 1
- op_b  out  DATA_W  operand 2
- op_rd  out  ADDR_W  destination index, passed through
- op_wr_en  out  1  destination write flag, passed through
- pending  out  32  scoreboard bit vector, one bit per register
- sb_err  out  1  sticky: write-back arrived for a non-pending register

Behaviour:
- Reset (rst_n low at a clk edge):
  - pending, op_valid, op_a, op_b, op_rd, op_wr_en and sb_err go to 0.
  - rf_wf, rf_rf and issue_ready are forced to 0 while rst_n is low.
  - An in-flight operand pair is dropped.
- Register-file ports are combinational from inputs:
  - rf_rs1 = issue_rs1, rf_rs2 = issue_rs2, rf_rf = issue_valid.
  - rf_ws = wb_rd, rf_wd = wb_data, rf_wf = wb_valid.
  - With HARDWIRE_R0=1, rf_wf = 0 when wb_rd = 0.
- Hazard terms, where clr(r) = wb_valid && wb_rd == r:
  - raw1 = issue_use_rs1 && pending[rs1] && !clr(rs1); raw2 is the same for rs2.
  - waw = issue_wr_en && pending[rd] && !clr(rd).
- issue_ready = rst_n && !raw1 && !raw2 && !waw && (!op_valid || op_ready).
- Accept = issue_valid && issue_ready. On accept, at the next edge:
  - op_valid = 1, so latency is exactly 1 cycle.
  - op_a = clr(rs1) ? wb_data : rf_rd1; op_b likewise for rs2. The bypass is applied even though the register file may already return the written value.
  - With HARDWIRE_R0=1, a source index of 0 yields 0.
  - op_rd and op_wr_en are captured.
- Output register hold and drain:
  - While op_valid && !op_ready, op_a, op_b, op_rd and op_wr_en hold stable.
  - op_valid clears when op_ready is high and there is no accept in the same cycle.
- Scoreboard update each edge:
  - Clear bit wb_rd on wb_valid, then set bit rd on accept with issue_wr_en.
  - Set wins when both hit the same index.
  - With HARDWIRE_R0=1, bit 0 is never set.
- wb_valid with pending[wb_rd] = 0: the register-file write is still performed and sb_err is set. sb_err clears only on reset.
- Write-back is never stalled; there is no ready on the wb interface.

Decomposition:
- Package regfile_pkg holds DATA_W, ADDR_W, NUM_REGS=32 and a typedef for the register index.
- One sub-module, reg_scoreboard:
  - Contains the 32-bit pending vector with set/clear ports.
  - Provides three lookup outputs for rs1, rs2 and rd, with clear-bypass.
- Operand capture and handshake logic stay in the top module.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with issue_valid=1 and wb_valid=1 -> rf_wf=0, issue_ready=0, op_valid=0, pending=0, sb_err=0.
- Basic read: issue rs1=2, rs2=3, rf_rd1=0x11, rf_rd2=0x22, op_ready=1 -> next cycle op_valid=1, op_a=0x11, op_b=0x22, op_rd passes through.
- RAW plus bypass:
  - Accept rd=5 with wr_en; pending[5]=1.
  - Issue rs1=5 -> issue_ready=0.
  - Assert wb_valid, wb_rd=5, wb_data=0xDEADBEEF -> accepted that cycle; op_a=0xDEADBEEF; pending[5]=0.
- Backpressure: op_ready=0 with op_valid=1 -> issue_ready=0 and op_a/op_b stable for 4 cycles; on op_ready=1 the next issue is accepted in the same cycle.
- WAW set-wins:
  - pending[7]=1; issue rd=7 while wb_rd=7 -> accepted.
  - pending[7] stays 1; rf_wf=1 with rf_ws=7.
- Spurious write-back: wb_valid with wb_rd=9 and pending[9]=0 -> rf_wf=1 and sb_err=1, sticky until reset.
